// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: request, response and ALU-side signals of the two-port ALU arbiter.
interface alu_req_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic [1:0]        req_valid, req_ready;
   logic [DATA_W-1:0] req_x0, req_y0, req_x1, req_y1;
   logic [OP_W-1:0]   req_op0, req_op1;
   logic [1:0]        rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_z;
   logic              rsp_overflow, rsp_equal, rsp_zero, rsp_err;
   logic [DATA_W-1:0] alu_x, alu_y, alu_z;
   logic [OP_W-1:0]   alu_op;
   logic              alu_overflow, alu_equal, alu_zero;
   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, req_op0, req_op1, rsp_ready,
             alu_z, alu_overflow, alu_equal, alu_zero,
      output req_ready, rsp_valid, rsp_z, rsp_overflow, rsp_equal, rsp_zero, rsp_err,
             alu_x, alu_y, alu_op
   );
   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, req_op0, req_op1, rsp_ready,
             alu_z, alu_overflow, alu_equal, alu_zero,
      input  req_ready, rsp_valid, rsp_z, rsp_overflow, rsp_equal, rsp_zero, rsp_err,
             alu_x, alu_y, alu_op
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one external ALU between two ports (IDLE/EXEC/RESP).
// Define ALU_ARB_OPCHECK_EN to trap reserved opcodes 11-15 and flag them on rsp_err.
module alu_req_arbiter (
   input logic          clk,
   input logic          rst,
   alu_req_arbiter_if.slave bus
);
   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t            state;
   logic              last_grant, gnt, g, hs, rsvd, bad_q, ov_q, eq_q, zr_q, err_q;
   logic [DATA_W-1:0] x_q, y_q, z_q, sel_x, sel_y;
   logic [OP_W-1:0]   op_q, sel_op;
   logic [1:0]        rv_q;
   // Contention goes to the port that was not served last.
   assign g             = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
   assign bus.req_ready = (state == IDLE && !rst && |bus.req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
   assign hs            = |(bus.req_valid & bus.req_ready);
   assign sel_x         = g ? bus.req_x1 : bus.req_x0;
   assign sel_y         = g ? bus.req_y1 : bus.req_y0;
   assign sel_op        = g ? bus.req_op1 : bus.req_op0;
`ifdef ALU_ARB_OPCHECK_EN
   assign rsvd = sel_op > 4'd10;
`else
   assign rsvd = 1'b0;
`endif
   assign bus.alu_x        = x_q;
   assign bus.alu_y        = y_q;
   assign bus.alu_op       = op_q;
   assign bus.rsp_valid    = rv_q;
   assign bus.rsp_z        = z_q;
   assign bus.rsp_overflow = ov_q;
   assign bus.rsp_equal    = eq_q;
   assign bus.rsp_zero     = zr_q;
   assign bus.rsp_err      = err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         op_q       <= '0;
         bad_q      <= 1'b0;
         z_q        <= '0;
         ov_q       <= 1'b0;
         eq_q       <= 1'b0;
         zr_q       <= 1'b0;
         err_q      <= 1'b0;
         rv_q       <= 2'b00;
      end else if (state == IDLE) begin
         if (hs) begin
            state      <= EXEC;
            gnt        <= g;
            last_grant <= g;
            x_q        <= sel_x;
            y_q        <= sel_y;
            op_q       <= rsvd ? '0 : sel_op;
            bad_q      <= rsvd;
         end
      end else if (state == EXEC) begin
         state <= RESP;
         z_q   <= bad_q ? '0 : bus.alu_z;
         ov_q  <= !bad_q && bus.alu_overflow;
         eq_q  <= !bad_q && bus.alu_equal;
         zr_q  <= !bad_q && bus.alu_zero;
         err_q <= bad_q;
         rv_q  <= gnt ? 2'b10 : 2'b01;
      end else if (bus.rsp_ready[gnt]) begin
         state <= IDLE;
         rv_q  <= 2'b00;
         x_q   <= '0;
         y_q   <= '0;
         op_q  <= '0;
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: transaction-level model of the arbiter plus a behavioural ALU, checked every cycle.
module tb_alu_req_arbiter;
   typedef struct {logic [31:0] x; logic [31:0] y; logic [3:0] op;} req_t;
   logic clk = 0, rst = 1;
   alu_req_arbiter_if bus ();
   alu_req_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   req_t q0[$], q1[$];
   int hs_cnt[2] = '{0, 0};
   int pop_cnt[2] = '{0, 0};
   int hs_port[$], hs_cyc[$], r_port[$];
   logic [31:0] r_z[$];
   logic [3:0] r_flg[$];
   int cyc = 0, th = 0;
   bit act = 0, tp = 0, mlast = 1;
   logic [31:0] tx, ty;
   logic [3:0] top;

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic logic [34:0] alu_fn(logic [31:0] x, logic [31:0] y, logic [3:0] op);
      logic [31:0] z;
      logic ov;
      ov = 1'b0;
      case (op)
         4'd0: z = x & y;
         4'd1: z = x | y;
         4'd2: z = x ^ y;
         4'd3: z = ~(x | y);
         4'd5: begin z = x + y; ov = (x[31] == y[31]) && (z[31] != x[31]); end
         4'd6: begin z = x - y; ov = (x[31] != y[31]) && (z[31] != x[31]); end
         4'd7: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd8: z = x >> y[4:0];
         4'd9: z = x << y[4:0];
         4'd10: z = $unsigned($signed(x) >>> y[4:0]);
         default: z = 32'd0;
      endcase
      return {z, ov, x == y, z == 32'd0};
   endfunction

   function automatic logic [3:0] exp_op(logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
      return op > 4'd10 ? 4'd0 : op;
`else
      return op;
`endif
   endfunction

   // Expected {z, overflow, equal, zero, err} for a request.
   function automatic logic [35:0] exp_rsp(logic [31:0] x, logic [31:0] y, logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
      if (op > 4'd10) return {35'd0, 1'b1};
`endif
      return {alu_fn(x, y, op), 1'b0};
   endfunction

   assign {bus.alu_z, bus.alu_overflow, bus.alu_equal, bus.alu_zero} = alu_fn(bus.alu_x, bus.alu_y, bus.alu_op);

   // Requesters: present queue heads, hold until the model records the handshake.
   initial begin
      bus.req_valid = 2'b00;
      {bus.req_x0, bus.req_y0, bus.req_x1, bus.req_y1} = '0;
      {bus.req_op0, bus.req_op1} = '0;
      forever begin
         @(posedge clk);
         #1;
         while (pop_cnt[0] < hs_cnt[0]) begin pop_cnt[0]++; if (q0.size() != 0) q0.delete(0); end
         while (pop_cnt[1] < hs_cnt[1]) begin pop_cnt[1]++; if (q1.size() != 0) q1.delete(0); end
         bus.req_valid = {q1.size() != 0, q0.size() != 0};
         if (q0.size() != 0) begin bus.req_x0 = q0[0].x; bus.req_y0 = q0[0].y; bus.req_op0 = q0[0].op; end
         if (q1.size() != 0) begin bus.req_x1 = q1[0].x; bus.req_y1 = q1[0].y; bus.req_op1 = q1[0].op; end
      end
   end

   // Model and per-cycle compare.
   always @(negedge clk) begin
      logic ep;
      logic [1:0] erdy;
      logic [35:0] r;
      int ph;
      cyc++;
      if (rst) begin
         act = 0;
         mlast = 1;
         chk("reset rsp_valid", bus.rsp_valid, 2'b00);
         chk("reset req_ready", bus.req_ready, 2'b00);
         chk("reset alu_x", bus.alu_x, 0);
      end else if (!act) begin
         ep = (bus.req_valid == 2'b11) ? !mlast : bus.req_valid[1];
         erdy = (bus.req_valid == 2'b00) ? 2'b00 : (ep ? 2'b10 : 2'b01);
         chk("idle req_ready", bus.req_ready, erdy);
         chk("idle rsp_valid", bus.rsp_valid, 2'b00);
         chk("idle alu_xy", {bus.alu_x, bus.alu_y}, 0);
         chk("idle alu_op", bus.alu_op, 0);
         if (erdy != 2'b00) begin
            act = 1;
            tp = ep;
            tx = ep ? bus.req_x1 : bus.req_x0;
            ty = ep ? bus.req_y1 : bus.req_y0;
            top = ep ? bus.req_op1 : bus.req_op0;
            th = cyc;
            mlast = ep;
            hs_port.push_back(int'(ep));
            hs_cyc.push_back(cyc);
            hs_cnt[ep]++;
         end
      end else begin
         ph = cyc - th;
         chk("busy req_ready", bus.req_ready, 2'b00);
         chk("busy alu_xy", {bus.alu_x, bus.alu_y}, {tx, ty});
         chk("busy alu_op", bus.alu_op, exp_op(top));
         chk("rsp_valid", bus.rsp_valid, ph >= 2 ? (tp ? 2'b10 : 2'b01) : 2'b00);
         if (ph >= 2) begin
            r = exp_rsp(tx, ty, top);
            chk("rsp_z", bus.rsp_z, r[35:4]);
            chk("rsp_flags_err", {bus.rsp_overflow, bus.rsp_equal, bus.rsp_zero, bus.rsp_err}, r[3:0]);
            if (bus.rsp_ready[tp]) begin
               r_port.push_back(int'(tp));
               r_z.push_back(bus.rsp_z);
               r_flg.push_back({bus.rsp_overflow, bus.rsp_equal, bus.rsp_zero, bus.rsp_err});
               act = 0;
            end
         end
      end
   end

   task automatic wait_idle(string n);
      int k = 0;
      while ((q0.size() != 0 || q1.size() != 0 || act || bus.req_valid != 2'b00) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({n, " completes"}, k < 300, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic wait_rsp(input int p, string n);
      int k = 0;
      while (!bus.rsp_valid[p] && k < 40) begin @(negedge clk); k++; end
      chk({n, " rsp seen"}, bus.rsp_valid[p], 1);
   endtask

   initial begin
      int b, rb;
      bus.rsp_ready = 2'b00;
      chk("model add", alu_fn(32'h7FFFFFFF, 32'h1, 4'd5), {32'h80000000, 3'b100});
      chk("model sub", alu_fn(32'd5, 32'd5, 4'd6), {32'd0, 3'b011});
      chk("model slt", alu_fn(32'hFFFFFFFF, 32'd1, 4'd7), {32'd1, 3'b000});
      repeat (3) @(posedge clk);
      #2;
      rst = 0;
      bus.rsp_ready = 2'b11;
      // ADD with signed overflow on port 0
      rb = r_z.size();
      q0.push_back('{32'h7FFFFFFF, 32'h1, 4'd5});
      wait_idle("add");
      chk("add port", r_port[rb], 0);
      chk("add z", r_z[rb], 32'h80000000);
      chk("add flags", r_flg[rb], 4'b1000);
      // contention straight after reset: port 0 first
      rst = 1;
      @(posedge clk);
      #2;
      rst = 0;
      b = hs_port.size();
      rb = r_z.size();
      q0.push_back('{32'd5, 32'd5, 4'd6});
      q1.push_back('{32'hF0, 32'h0F, 4'd1});
      wait_idle("contend");
      chk("contend first", hs_port[b], 0);
      chk("contend second", hs_port[b+1], 1);
      chk("contend spacing", hs_cyc[b+1] - hs_cyc[b], 3);
      chk("sub z", r_z[rb], 0);
      chk("sub flags", r_flg[rb], 4'b0110);
      chk("or z", r_z[rb+1], 32'hFF);
      // six ops under continuous contention alternate
      b = hs_port.size();
      for (int i = 0; i < 3; i++) begin
         q0.push_back('{32'(i), 32'h3, 4'(2 + i)});
         q1.push_back('{32'hF0F0 + 32'(i), 32'(i + 1), 4'(8 + i)});
      end
      wait_idle("alternate");
      for (int i = 0; i < 6; i++) chk($sformatf("alt grant %0d", i), hs_port[b+i], i % 2);
      // port 1 SLT under backpressure, port 0 waiting
      bus.rsp_ready = 2'b00;
      q1.push_back('{32'hFFFFFFFF, 32'd1, 4'd7});
      wait_rsp(1, "slt");
      q0.push_back('{32'h9, 32'h9, 4'd2});
      for (int i = 0; i < 4; i++) begin
         chk("hold rsp_valid", bus.rsp_valid, 2'b10);
         chk("hold rsp_z", bus.rsp_z, 1);
         chk("hold req_ready", bus.req_ready, 2'b00);
         @(negedge clk);
      end
      @(posedge clk);
      #2;
      bus.rsp_ready = 2'b11;
      wait_idle("backpressure");
      // reserved opcode
      rb = r_z.size();
      q0.push_back('{32'h1234, 32'h1234, 4'd12});
      wait_idle("reserved");
`ifdef ALU_ARB_OPCHECK_EN
      chk("rsvd flags_err", r_flg[rb], 4'b0001);
`else
      chk("rsvd flags_err", r_flg[rb], 4'b0110);
`endif
      chk("rsvd z", r_z[rb], 0);
      // reset while a response is pending
      bus.rsp_ready = 2'b00;
      q0.push_back('{32'h3, 32'h4, 4'd5});
      wait_rsp(0, "pre-reset");
      rb = r_z.size();
      @(posedge clk);
      #2;
      rst = 1;
      q0.delete();
      q1.delete();
      #1;
      chk("async rsp_valid drop", bus.rsp_valid, 2'b00);
      repeat (2) @(posedge clk);
      #2;
      rst = 0;
      bus.rsp_ready = 2'b11;
      b = hs_port.size();
      q0.push_back('{32'h1, 32'h2, 4'd0});
      q1.push_back('{32'h3, 32'h4, 4'd3});
      wait_idle("post-reset");
      chk("no discarded response", r_z.size(), rb + 2);
      chk("post-reset first", hs_port[b], 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
